plic_axi_arbiter: RTL and testbench

PLIC_AXI_ARBITER -- requirements
Module: plic_axi_arbiter

---
 rtl/plic_axi_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_plic_axi_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/plic_axi_arbiter.sv
// plic_axi_arbiter
//   Two-master to one-slave AXI4 arbiter in front of the PLIC register port.
//   Read and write channels are arbitrated independently, each by its own
//   FSM; a grant is held for the whole burst (read) or until the write
//   response is accepted (write).
//
// Configuration macro:
//   PLIC_ARB_FIXED_PRIO_EN - when defined, master 0 always wins simultaneous
//                            requests and no round-robin pointers exist.
//                            Default (undefined): per-channel round-robin.
//
// Ports:
//   PCLK, PRESET            clock, asynchronous active-high reset
//   m_ar*/m_r*              two AXI4 read masters, master 0 in the low slice
//   m_aw*/m_w*/m_b*         two AXI4 write masters, master 0 in the low slice
//   s_ar*/s_r*              read channels toward the PLIC slave port
//   s_aw*/s_w*/s_b*         write channels toward the PLIC slave port
//   r_gnt, w_gnt            one-hot current read / write owner, 0 when idle
module plic_axi_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 8
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  // master read address
  input  logic [2*ADDR_BITS-1:0]     m_araddr,
  input  logic [5:0]                 m_arsize,
  input  logic [2*LEN_BITS-1:0]      m_arlen,
  input  logic [3:0]                 m_arburst,
  input  logic [1:0]                 m_arvalid,
  output logic [1:0]                 m_arready,
  // master read data
  output logic [2*DATA_BITS-1:0]     m_rdata,
  output logic [3:0]                 m_rresp,
  output logic [1:0]                 m_rvalid,
  output logic [1:0]                 m_rlast,
  input  logic [1:0]                 m_rready,
  // master write address
  input  logic [2*ADDR_BITS-1:0]     m_awaddr,
  input  logic [5:0]                 m_awsize,
  input  logic [2*LEN_BITS-1:0]      m_awlen,
  input  logic [3:0]                 m_awburst,
  input  logic [1:0]                 m_awvalid,
  output logic [1:0]                 m_awready,
  // master write data
  input  logic [2*DATA_BITS-1:0]     m_wdata,
  input  logic [2*(DATA_BITS/8)-1:0] m_wstrb,
  input  logic [1:0]                 m_wlast,
  input  logic [1:0]                 m_wvalid,
  output logic [1:0]                 m_wready,
  // master write response
  output logic [3:0]                 m_bresp,
  output logic [1:0]                 m_bvalid,
  input  logic [1:0]                 m_bready,
  // slave read address
  output logic [ADDR_BITS-1:0]       s_araddr,
  output logic [2:0]                 s_arsize,
  output logic [LEN_BITS-1:0]        s_arlen,
  output logic [1:0]                 s_arburst,
  output logic                       s_arvalid,
  input  logic                       s_arready,
  // slave read data
  input  logic [DATA_BITS-1:0]       s_rdata,
  input  logic [1:0]                 s_rresp,
  input  logic                       s_rvalid,
  input  logic                       s_rlast,
  output logic                       s_rready,
  // slave write address
  output logic [ADDR_BITS-1:0]       s_awaddr,
  output logic [2:0]                 s_awsize,
  output logic [LEN_BITS-1:0]        s_awlen,
  output logic [1:0]                 s_awburst,
  output logic                       s_awvalid,
  input  logic                       s_awready,
  // slave write data
  output logic [DATA_BITS-1:0]       s_wdata,
  output logic [DATA_BITS/8-1:0]     s_wstrb,
  output logic                       s_wlast,
  output logic                       s_wvalid,
  input  logic                       s_wready,
  // slave write response
  input  logic [1:0]                 s_bresp,
  input  logic                       s_bvalid,
  output logic                       s_bready,
  // grants
  output logic [1:0]                 r_gnt,
  output logic [1:0]                 w_gnt
);

  localparam int STRB_BITS = DATA_BITS / 8;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  r_state_t            r_state, r_state_nxt;
  w_state_t            w_state, w_state_nxt;
  logic [1:0]          r_gnt_nxt, w_gnt_nxt;
  logic [LEN_BITS-1:0] r_cnt, r_cnt_nxt;
  logic [1:0]          r_win, w_win;
  logic                r_own, w_own;

  // Grants are one-hot, so bit 1 doubles as the owner index.
  assign r_own = r_gnt[1];
  assign w_own = w_gnt[1];

`ifdef PLIC_ARB_FIXED_PRIO_EN
  assign r_win = m_arvalid[0] ? 2'b01 : {m_arvalid[1], 1'b0};
  assign w_win = m_awvalid[0] ? 2'b01 : {m_awvalid[1], 1'b0};
`else
  // Pointer holds the index of the master favoured on a tie: the one after
  // the last owner. It only moves when a burst/response completes.
  logic r_ptr, w_ptr;

  assign r_win = (&m_arvalid) ? (r_ptr ? 2'b10 : 2'b01) : m_arvalid;
  assign w_win = (&m_awvalid) ? (w_ptr ? 2'b10 : 2'b01) : m_awvalid;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ptr <= 1'b0;
      w_ptr <= 1'b0;
    end else begin
      if (r_state == R_DATA && s_rvalid && s_rready && r_cnt == '0)
        r_ptr <= ~r_own;
      if (w_state == W_RESP && s_bvalid && s_bready)
        w_ptr <= ~w_own;
    end
  end
`endif

  // State registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      r_gnt   <= 2'b00;
      w_gnt   <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_state <= r_state_nxt;
      w_state <= w_state_nxt;
      r_gnt   <= r_gnt_nxt;
      w_gnt   <= w_gnt_nxt;
      r_cnt   <= r_cnt_nxt;
    end
  end

  // Read FSM next state
  always_comb begin
    r_state_nxt = r_state;
    r_gnt_nxt   = r_gnt;
    r_cnt_nxt   = r_cnt;
    case (r_state)
      R_IDLE: if (|m_arvalid) begin
        r_gnt_nxt   = r_win;
        r_state_nxt = R_ADDR;
      end
      R_ADDR: if (s_arvalid && s_arready) begin
        r_cnt_nxt   = s_arlen;
        r_state_nxt = R_DATA;
      end
      R_DATA: if (s_rvalid && s_rready) begin
        if (r_cnt == '0) begin
          r_gnt_nxt   = 2'b00;
          r_state_nxt = R_IDLE;
        end else begin
          r_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        r_gnt_nxt   = 2'b00;
        r_state_nxt = R_IDLE;
      end
    endcase
  end

  // Write FSM next state
  always_comb begin
    w_state_nxt = w_state;
    w_gnt_nxt   = w_gnt;
    case (w_state)
      W_IDLE: if (|m_awvalid) begin
        w_gnt_nxt   = w_win;
        w_state_nxt = W_ADDR;
      end
      W_ADDR: if (s_awvalid && s_awready) w_state_nxt = W_DATA;
      W_DATA: if (s_wvalid && s_wready && s_wlast) w_state_nxt = W_RESP;
      W_RESP: if (s_bvalid && s_bready) begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = W_IDLE;
      end
      default: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = W_IDLE;
      end
    endcase
  end

  // Per-phase owner masks: zero outside the phase, so every handshake
  // signal and every non-owner output is forced low.
  logic [1:0] ar_sel, r_sel, aw_sel, wd_sel, b_sel;
  assign ar_sel = (r_state == R_ADDR) ? r_gnt : 2'b00;
  assign r_sel  = (r_state == R_DATA) ? r_gnt : 2'b00;
  assign aw_sel = (w_state == W_ADDR) ? w_gnt : 2'b00;
  assign wd_sel = (w_state == W_DATA) ? w_gnt : 2'b00;
  assign b_sel  = (w_state == W_RESP) ? w_gnt : 2'b00;

  // Slave-side payload muxes
  assign s_araddr  = r_own ? m_araddr[ADDR_BITS +: ADDR_BITS] : m_araddr[0 +: ADDR_BITS];
  assign s_arsize  = r_own ? m_arsize[5:3]                    : m_arsize[2:0];
  assign s_arlen   = r_own ? m_arlen[LEN_BITS +: LEN_BITS]    : m_arlen[0 +: LEN_BITS];
  assign s_arburst = r_own ? m_arburst[3:2]                   : m_arburst[1:0];
  assign s_awaddr  = w_own ? m_awaddr[ADDR_BITS +: ADDR_BITS] : m_awaddr[0 +: ADDR_BITS];
  assign s_awsize  = w_own ? m_awsize[5:3]                    : m_awsize[2:0];
  assign s_awlen   = w_own ? m_awlen[LEN_BITS +: LEN_BITS]    : m_awlen[0 +: LEN_BITS];
  assign s_awburst = w_own ? m_awburst[3:2]                   : m_awburst[1:0];
  assign s_wdata   = w_own ? m_wdata[DATA_BITS +: DATA_BITS]  : m_wdata[0 +: DATA_BITS];
  assign s_wstrb   = w_own ? m_wstrb[STRB_BITS +: STRB_BITS]  : m_wstrb[0 +: STRB_BITS];
  assign s_wlast   = w_own ? m_wlast[1]                       : m_wlast[0];

  // Handshakes
  assign s_arvalid = |(ar_sel & m_arvalid);
  assign m_arready = ar_sel & {2{s_arready}};
  assign s_rready  = |(r_sel & m_rready);
  assign s_awvalid = |(aw_sel & m_awvalid);
  assign m_awready = aw_sel & {2{s_awready}};
  assign s_wvalid  = |(wd_sel & m_wvalid);
  assign m_wready  = wd_sel & {2{s_wready}};
  assign s_bready  = |(b_sel & m_bready);

  // Master-side return paths
  assign m_rvalid = r_sel & {2{s_rvalid}};
  assign m_rlast  = r_sel & {2{s_rlast}};
  assign m_rdata  = {{DATA_BITS{r_sel[1]}}, {DATA_BITS{r_sel[0]}}} & {2{s_rdata}};
  assign m_rresp  = {{2{r_sel[1]}}, {2{r_sel[0]}}} & {2{s_rresp}};
  assign m_bvalid = b_sel & {2{s_bvalid}};
  assign m_bresp  = {{2{b_sel[1]}}, {2{b_sel[0]}}} & {2{s_bresp}};

endmodule

// File: tb/tb_plic_axi_arbiter.sv
// Directed testbench for plic_axi_arbiter (default parameters).
// Builds with or without PLIC_ARB_FIXED_PRIO_EN; tie-break expectations
// follow the macro.
module tb_plic_axi_arbiter;
  localparam int A = 32;
  localparam int D = 32;
  localparam int L = 8;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  logic [2*A-1:0] m_araddr, m_awaddr;
  logic [5:0] m_arsize, m_awsize;
  logic [2*L-1:0] m_arlen, m_awlen;
  logic [3:0] m_arburst, m_awburst;
  logic [1:0] m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [2*D-1:0] m_rdata, m_wdata;
  logic [3:0] m_rresp, m_bresp;
  logic [1:0] m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [2*(D/8)-1:0] m_wstrb;
  logic [A-1:0] s_araddr, s_awaddr;
  logic [2:0] s_arsize, s_awsize;
  logic [L-1:0] s_arlen, s_awlen;
  logic [1:0] s_arburst, s_awburst, s_rresp, s_bresp;
  logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [D-1:0] s_rdata, s_wdata;
  logic [D/8-1:0] s_wstrb;
  logic [1:0] r_gnt, w_gnt;

  int n_checks = 0;
  int n_fail = 0;

  plic_axi_arbiter #(.ADDR_BITS(A), .DATA_BITS(D), .LEN_BITS(L)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arlen(m_arlen), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awlen(m_awlen), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .r_gnt(r_gnt), .w_gnt(w_gnt)
  );

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset;
    m_araddr = '0; m_arsize = '0; m_arlen = '0; m_arburst = '0; m_arvalid = '0; m_rready = 2'b11;
    m_awaddr = '0; m_awsize = '0; m_awlen = '0; m_awburst = '0; m_awvalid = '0;
    m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0; s_rlast = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
    PRESET = 1'b1;
    tick(); tick();
    // requests held during reset must not be granted
    m_arvalid = 2'b11; m_awvalid = 2'b11;
    tick();
    n_checks++; if (r_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_r_gnt: got %b want 00", r_gnt); end
    n_checks++; if (w_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_w_gnt: got %b want 00", w_gnt); end
    n_checks++; if ({s_arvalid, s_awvalid, s_wvalid} !== 3'b000) begin n_fail++; $display("FAIL reset_s_valid: got %b want 000", {s_arvalid, s_awvalid, s_wvalid}); end
    n_checks++; if ({m_arready, m_awready, m_wready, m_rvalid, m_bvalid} !== 10'b0) begin n_fail++; $display("FAIL reset_m_hs: got %b want 0", {m_arready, m_awready, m_wready, m_rvalid, m_bvalid}); end
    m_arvalid = 2'b00; m_awvalid = 2'b00;
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    logic [1:0] exp2;
    m_araddr = {32'h2000_0000, 32'h1000_0000}; m_arlen = '0; s_rlast = 1;
    m_arvalid = 2'b11;
    #1;
    n_checks++; if (r_gnt !== 2'b00) begin n_fail++; $display("FAIL rr_latency: got %b want 00", r_gnt); end
    tick();
    n_checks++; if (r_gnt !== 2'b01) begin n_fail++; $display("FAIL rr_first: got %b want 01", r_gnt); end
    n_checks++; if (s_araddr !== 32'h1000_0000) begin n_fail++; $display("FAIL rr_araddr: got %h want 10000000", s_araddr); end
    s_arready = 1; #1;
    n_checks++; if (m_arready !== 2'b01) begin n_fail++; $display("FAIL rr_arready: got %b want 01", m_arready); end
    tick();
    m_arvalid = 2'b10; s_arready = 0; s_rvalid = 1; s_rdata = 32'hCAFE_0001; #1;
    n_checks++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL rr_rvalid: got %b want 01", m_rvalid); end
    n_checks++; if (m_rdata !== 64'h0000_0000_CAFE_0001) begin n_fail++; $display("FAIL rr_rdata: got %h want 00000000cafe0001", m_rdata); end
    tick();
    s_rvalid = 0; m_arvalid = 2'b11;
    n_checks++; if (r_gnt !== 2'b00) begin n_fail++; $display("FAIL rr_release: got %b want 00", r_gnt); end
    tick();
`ifdef PLIC_ARB_FIXED_PRIO_EN
    exp2 = 2'b01;
`else
    exp2 = 2'b10;
`endif
    n_checks++; if (r_gnt !== exp2) begin n_fail++; $display("FAIL rr_second: got %b want %b", r_gnt, exp2); end
    s_arready = 1; tick();
    m_arvalid = 2'b00; s_arready = 0; s_rvalid = 1; tick();
    s_rvalid = 0; tick();
  endtask

  task automatic test_long_burst;
    m_arvalid = 2'b10; m_arlen = {8'd3, 8'd0}; m_araddr = {32'h3000_0010, 32'h0};
    tick();
    n_checks++; if (r_gnt !== 2'b10) begin n_fail++; $display("FAIL lb_gnt: got %b want 10", r_gnt); end
    s_arready = 1; tick();
    m_arvalid = 2'b00; s_arready = 0;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1; s_rdata = 32'hB000_0000 + i; s_rlast = (i == 3);
      if (i == 1) m_arvalid = 2'b01;
      #1;
      n_checks++; if (m_rvalid !== 2'b10) begin n_fail++; $display("FAIL lb_rvalid beat %0d: got %b want 10", i, m_rvalid); end
      n_checks++; if (m_rdata !== {32'hB000_0000 + i, 32'h0}) begin n_fail++; $display("FAIL lb_rdata beat %0d: got %h", i, m_rdata); end
      n_checks++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL lb_no_ar beat %0d: got %b want 0", i, s_arvalid); end
      tick();
      if (i < 3) begin
        n_checks++; if (r_gnt !== 2'b10) begin n_fail++; $display("FAIL lb_hold beat %0d: got %b want 10", i, r_gnt); end
      end
    end
    s_rvalid = 0; m_arlen = '0;
    n_checks++; if (r_gnt !== 2'b00) begin n_fail++; $display("FAIL lb_end: got %b want 00", r_gnt); end
    tick();
    n_checks++; if (r_gnt !== 2'b01) begin n_fail++; $display("FAIL lb_waiter: got %b want 01", r_gnt); end
    s_arready = 1; tick();
    m_arvalid = 2'b00; s_arready = 0; s_rvalid = 1; s_rlast = 1; tick();
    s_rvalid = 0; tick();
  endtask

  task automatic test_concurrent;
    m_awvalid = 2'b01; m_awaddr = {32'h0, 32'h1000_0004}; m_awlen = '0;
    m_arvalid = 2'b10; m_araddr = {32'h1000_0004, 32'h0}; m_arlen = '0;
    tick();
    n_checks++; if ({w_gnt, r_gnt} !== 4'b0110) begin n_fail++; $display("FAIL cc_gnts: w=%b r=%b want w=01 r=10", w_gnt, r_gnt); end
    n_checks++; if (s_awaddr !== 32'h1000_0004 || s_araddr !== 32'h1000_0004) begin n_fail++; $display("FAIL cc_addr: aw=%h ar=%h want 10000004", s_awaddr, s_araddr); end
    s_awready = 1; s_arready = 1; tick();
    m_awvalid = 0; m_arvalid = 0; s_awready = 0; s_arready = 0;
    m_wvalid = 2'b01; m_wdata = {32'h0, 32'h7}; m_wstrb = 8'h0F; m_wlast = 2'b01; s_wready = 1;
    s_rvalid = 1; s_rdata = 32'h7; s_rlast = 1; #1;
    n_checks++; if (s_wdata !== 32'h7 || s_wvalid !== 1'b1 || s_wstrb !== 4'hF) begin n_fail++; $display("FAIL cc_wdata: got %h v=%b strb=%h want 7 1 f", s_wdata, s_wvalid, s_wstrb); end
    n_checks++; if (m_wready !== 2'b01 || m_rvalid !== 2'b10) begin n_fail++; $display("FAIL cc_data_route: wready=%b rvalid=%b want 01 10", m_wready, m_rvalid); end
    tick();
    m_wvalid = 0; m_wlast = 0; s_wready = 0; s_rvalid = 0;
    s_bvalid = 1; s_bresp = 2'b00; m_bready = 2'b01; #1;
    n_checks++; if (m_bvalid !== 2'b01 || m_bresp !== 4'h0 || s_bready !== 1'b1) begin n_fail++; $display("FAIL cc_bresp: bvalid=%b bresp=%h bready=%b want 01 0 1", m_bvalid, m_bresp, s_bready); end
    tick();
    s_bvalid = 0; m_bready = 0;
    n_checks++; if (w_gnt !== 2'b00) begin n_fail++; $display("FAIL cc_w_release: got %b want 00", w_gnt); end
    tick();
  endtask

  task automatic test_w_burst;
    m_awvalid = 2'b01; m_awlen = {8'd0, 8'd1};
    tick();
    s_awready = 1; tick();
    m_awvalid = 0; s_awready = 0;
    m_wvalid = 2'b01; m_wlast = 2'b00; s_wready = 1;
    tick();
    s_bvalid = 1; s_bresp = 2'b10; m_bready = 2'b11; #1;
    n_checks++; if (m_bvalid !== 2'b00 || s_bready !== 1'b0) begin n_fail++; $display("FAIL wb_early_resp: bvalid=%b bready=%b want 00 0", m_bvalid, s_bready); end
    m_wlast = 2'b01; #1;
    n_checks++; if (s_wlast !== 1'b1 || m_wready !== 2'b01) begin n_fail++; $display("FAIL wb_beat2: wlast=%b wready=%b want 1 01", s_wlast, m_wready); end
    tick();
    m_wvalid = 0; m_wlast = 0; s_wready = 0; #1;
    n_checks++; if (m_bvalid !== 2'b01) begin n_fail++; $display("FAIL wb_bvalid: got %b want 01", m_bvalid); end
    n_checks++; if (m_bresp !== 4'b0010) begin n_fail++; $display("FAIL wb_bresp: got %b want 0010", m_bresp); end
    tick();
    s_bvalid = 0; m_bready = 0;
    n_checks++; if (w_gnt !== 2'b00) begin n_fail++; $display("FAIL wb_release: got %b want 00", w_gnt); end
    m_awlen = '0;
    tick();
  endtask

  task automatic test_reset_mid;
    m_arvalid = 2'b01; m_araddr = {32'h0, 32'h100}; m_arlen = {8'd0, 8'd3};
    tick();
    s_arready = 1; tick();
    m_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rlast = 0; s_rdata = 32'hAA; #1;
    n_checks++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL rm_pre: got %b want 01", m_rvalid); end
    tick();
    PRESET = 1; #1;
    n_checks++; if (r_gnt !== 2'b00 || m_rvalid !== 2'b00 || s_rready !== 1'b0) begin n_fail++; $display("FAIL rm_async: gnt=%b rvalid=%b rready=%b want 00 00 0", r_gnt, m_rvalid, s_rready); end
    n_checks++; if (m_rdata !== 64'h0 || s_arvalid !== 1'b0) begin n_fail++; $display("FAIL rm_quiet: rdata=%h arvalid=%b want 0 0", m_rdata, s_arvalid); end
    tick();
    PRESET = 0; s_rvalid = 0; m_arvalid = 2'b11; m_arlen = '0;
    tick();
    n_checks++; if (r_gnt !== 2'b01) begin n_fail++; $display("FAIL rm_regrant: got %b want 01", r_gnt); end
    n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rm_no_rvalid: got %b want 00", m_rvalid); end
    m_arvalid = 2'b00;
  endtask

  task automatic test_fixed_prio;
    logic [1:0] exp2;
    PRESET = 1; tick();
    PRESET = 0; m_arvalid = 2'b11; m_arlen = '0; s_rlast = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef PLIC_ARB_FIXED_PRIO_EN
      exp2 = 2'b01;
`else
      exp2 = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      n_checks++; if (r_gnt !== exp2) begin n_fail++; $display("FAIL fp_round %0d: got %b want %b", i, r_gnt, exp2); end
      s_arready = 1; tick();
      s_arready = 0; s_rvalid = 1; tick();
      s_rvalid = 0;
    end
    m_arvalid = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_long_burst();
    test_concurrent();
    test_w_burst();
    test_reset_mid();
    test_fixed_prio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
